if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC and issues word fetches to an instruction memory that has variable latency, using a request/response handshake.
- Captures each returned instruction into the IF/ID pipeline register, which feeds the decode/register-file stage directly downstream.
- Honours stall from the hazard unit and PC redirects (branch, J/JAL, JR) resolved downstream.

---
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request/response
// fetch to a variable-latency instruction memory and loads the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        id_valid_d;
    logic [31:0] id_instr_d, id_pc_d, id_pc4_d;

    logic        capture;
    logic [31:0] cap_instr, cap_pc;

    // Targets are word aligned; the low two bits are dropped on purpose.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^redirect_pc[1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        capture      = 1'b0;
        cap_instr    = 32'h0;
        cap_pc       = 32'h0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (!stall) begin
                            capture   = 1'b1;
                            cap_instr = imem_rdata;
                            cap_pc    = pc_q;
                            state_d   = S_REQ;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    capture      = 1'b1;
                    cap_instr    = skid_instr_q;
                    cap_pc       = skid_pc_q;
                    skid_instr_d = 32'h0;
                    skid_pc_d    = 32'h0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect beats stall everywhere; an already accepted fetch must be drained.
        if (redirect) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            skid_instr_d = 32'h0;
            skid_pc_d    = 32'h0;
            capture      = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        id_valid_d = id_valid;
        id_instr_d = id_instr;
        id_pc_d    = id_pc;
        id_pc4_d   = id_pc4;
        if (redirect || (!stall && !capture)) begin
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
        end else if (capture) begin
            id_valid_d = 1'b1;
            id_instr_d = cap_instr;
            id_pc_d    = cap_pc;
            id_pc4_d   = cap_pc + 32'd4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            id_valid     <= 1'b0;
            id_instr     <= 32'h0;
            id_pc        <= 32'h0;
            id_pc4       <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid     <= id_valid_d;
            id_instr     <= id_instr_d;
            id_pc        <= id_pc_d;
            id_pc4       <= id_pc4_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table and hand sequences, then random
// stimulus checked against a fetch-stream scoreboard.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] pc4);
        vec_t t;
        t.stall = s;  t.redirect = r; t.redirect_pc = rpc; t.ready = rdy;
        t.rvalid = rv; t.rdata = rd;  t.req = req;         t.addr = addr;
        t.v = v;       t.instr = ins; t.pc = pc;           t.pc4 = pc4;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},    {31'h0, imem_req}, 32'h0);
        check({tag, ".addr"},   imem_addr, RESET_PC);
        check({tag, ".valid"},  {31'h0, id_valid}, 32'h0);
        check({tag, ".instr"},  id_instr, 32'h0);
        check({tag, ".id_pc"},  id_pc, 32'h0);
        check({tag, ".id_pc4"}, id_pc4, 32'h0);
    endtask

    // Called at a negedge: drive, take one rising edge, compare, return at the next negedge.
    task automatic step(input vec_t t, input string tag);
        stall       = t.stall;
        redirect    = t.redirect;
        redirect_pc = t.redirect_pc;
        imem_ready  = t.ready;
        imem_rvalid = t.rvalid;
        imem_rdata  = t.rdata;
        @(posedge clk);
        #1;
        check({tag, ".req"},   {31'h0, imem_req}, {31'h0, t.req});
        check({tag, ".addr"},  imem_addr, t.addr);
        check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, t.v});
        check({tag, ".instr"}, id_instr, t.instr);
        if (t.v) begin
            check({tag, ".id_pc"},  id_pc, t.pc);
            check({tag, ".id_pc4"}, id_pc4, t.pc4);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl[24];
        fetch_t      kq[$];
        fetch_t      f;
        logic        outst, stale, hold_prev, req_s, accept, exp_v;
        logic [31:0] out_addr, exp_next, addr_s, prev_addr, exp_i, exp_pc, exp_pc4;
        int          lat, idle_cycles, max_idle;

        // stall redir rpc ready rvalid rdata | req addr valid instr id_pc id_pc4
        tbl[0]  = mk(0, 0, 0, 1, 0, 0,                       1, 32'h0,   0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0, 0,                       0, 32'h0,   0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, inst(32'h0),             1, 32'h4,   1, inst(32'h0), 32'h0, 32'h4);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0,                       0, 32'h4,   0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, inst(32'h4),             1, 32'h8,   1, inst(32'h4), 32'h4, 32'h8);
        tbl[5]  = mk(1, 0, 0, 1, 0, 0,                       0, 32'h8,   1, inst(32'h4), 32'h4, 32'h8);
        tbl[6]  = mk(1, 0, 0, 0, 1, inst(32'h8),             0, 32'hC,   1, inst(32'h4), 32'h4, 32'h8);
        tbl[7]  = mk(1, 0, 0, 1, 0, 0,                       0, 32'hC,   1, inst(32'h4), 32'h4, 32'h8);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0,                       1, 32'hC,   1, inst(32'h8), 32'h8, 32'hC);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0,                       0, 32'hC,   0, 0, 0, 0);
        tbl[10] = mk(0, 1, 32'h103, 0, 0, 0,                 0, 32'h100, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, inst(32'hC),             1, 32'h100, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 0,                       0, 32'h100, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, inst(32'h100),           1, 32'h104, 1, inst(32'h100), 32'h100, 32'h104);
        tbl[14] = mk(1, 1, 32'h40, 0, 0, 0,                  1, 32'h40,  0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0,                       1, 32'h40,  0, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 0, 0,                       0, 32'h40,  0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, inst(32'h40),            1, 32'h44,  1, inst(32'h40), 32'h40, 32'h44);
        tbl[18] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0,           1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 1, 0, 0,                       0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 1, inst(32'hFFFF_FFFC),     1, 32'h0,   1, inst(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        tbl[21] = mk(0, 0, 0, 1, 0, 0,                       0, 32'h0,   0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 1, inst(32'h0),             1, 32'h4,   1, inst(32'h0), 32'h0, 32'h4);
        tbl[23] = mk(1, 0, 0, 1, 0, 0,                       0, 32'h4,   1, inst(32'h0), 32'h0, 32'h4);

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset while a fetch is outstanding, then a late response.
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        step(mk(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, RESET_PC, 0, 0, 0, 0), "in_rst");
        check_reset_outputs("in_rst_all");
        rst = 1'b1;
        step(mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, RESET_PC, 0, 0, 0, 0), "late_rv0");
        step(mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, RESET_PC, 0, 0, 0, 0), "late_rv1");
        step(mk(0, 0, 0, 1, 0, 0,             0, RESET_PC, 0, 0, 0, 0), "post_rst_acc");
        step(mk(0, 0, 0, 0, 1, inst(RESET_PC), 1, RESET_PC + 32'd4, 1, inst(RESET_PC),
                RESET_PC, RESET_PC + 32'd4), "post_rst_cap");

        // Random phase: memory with latency 1..3, scoreboard of kept fetches.
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        outst = 1'b0; stale = 1'b0; lat = 0; out_addr = 32'h0;
        exp_next = RESET_PC; kq.delete(); hold_prev = 1'b0; prev_addr = 32'h0;
        exp_v = 1'b0; exp_i = 32'h0; exp_pc = 32'h0; exp_pc4 = 32'h0;
        idle_cycles = 0; max_idle = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_s  = imem_req;
            addr_s = imem_addr;
            if (hold_prev) begin
                check("rnd.req_held",  {31'h0, req_s}, 32'h1);
                check("rnd.addr_held", addr_s, prev_addr);
            end
            if (kq.size() > 0) check("rnd.no_fetch_while_parked", {31'h0, req_s}, 32'h0);

            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
            imem_ready  = ($urandom_range(0, 2) != 0);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (outst) begin
                lat--;
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst(out_addr);
                end
            end

            @(posedge clk);
            accept = req_s && imem_ready;
            if (imem_rvalid) begin
                if (!stale && !redirect) begin
                    f.pc = out_addr; f.instr = inst(out_addr);
                    kq.push_back(f);
                    exp_next = out_addr + 32'd4;
                end
                outst = 1'b0;
            end
            if (accept) begin
                check("rnd.single_outstanding", {31'h0, outst}, 32'h0);
                if (!redirect) check("rnd.fetch_addr", addr_s, exp_next);
                outst = 1'b1; stale = redirect; lat = $urandom_range(1, 3); out_addr = addr_s;
                idle_cycles = 0;
            end else begin
                if (redirect && outst) stale = 1'b1;
                idle_cycles++;
                if (idle_cycles > max_idle) max_idle = idle_cycles;
            end
            if (redirect) begin
                exp_next = {redirect_pc[31:2], 2'b00};
                kq.delete();
            end
            hold_prev = req_s && !imem_ready && !redirect;
            prev_addr = addr_s;

            if (redirect) begin
                exp_v = 1'b0; exp_i = 32'h0;
            end else if (!stall) begin
                if (kq.size() > 0) begin
                    f = kq.pop_front();
                    exp_v = 1'b1; exp_i = f.instr; exp_pc = f.pc; exp_pc4 = f.pc + 32'd4;
                end else begin
                    exp_v = 1'b0; exp_i = 32'h0;
                end
            end

            #1;
            check("rnd.id_valid", {31'h0, id_valid}, {31'h0, exp_v});
            check("rnd.id_instr", id_instr, exp_i);
            if (exp_v) begin
                check("rnd.id_pc",  id_pc, exp_pc);
                check("rnd.id_pc4", id_pc4, exp_pc4);
            end
            @(negedge clk);
        end
        check("rnd.max_cycles_between_fetches_below_200", {31'h0, (max_idle < 200)}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
